// File: rtl/inst_encoder_if.sv
// Handshake bundle for inst_encoder: symbolic instruction input, tagged word output, status.
// master = instruction source / word sink side, slave = the encoder itself.
interface inst_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic [15:0]       count;
    logic              err;
    logic [2:0]        err_op;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, count, err, err_op
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
        output in_ready, out_valid, out_instr, out_addr, count, err, err_op
    );
endinterface

// File: rtl/inst_encoder.sv
// Streaming MIPS encoder (addu/addiu/sw/lw/jal): packs each accepted op, tags it with a word
// address and queues it in a DEPTH-entry FIFO. Define INST_ENCODER_ERR_EN for sticky invalid-op capture.
module inst_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 4
) (
    input  logic          clk,
    input  logic          rst,
    inst_encoder_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;

    localparam logic [2:0] OP_ADDU  = 3'd0;
    localparam logic [2:0] OP_ADDIU = 3'd1;
    localparam logic [2:0] OP_SW    = 3'd2;
    localparam logic [2:0] OP_LW    = 3'd3;
    localparam logic [2:0] OP_JAL   = 3'd4;

    localparam logic [OCC_W-1:0]  OCC_FULL   = OCC_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_RESET = ADDR_W'(BASE_ADDR);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       instr;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       count_q, count_d;

    logic [31:0] instr_enc;
    logic        op_valid;
    logic        full;
    logic        empty;
    logic        accept;
    logic        push;
    logic        pop;

    // Field packing matches the core decoder; fields an op does not use are ignored.
    always_comb begin
        instr_enc = 32'd0;
        op_valid  = 1'b1;
        case (bus.in_op)
            OP_ADDU:  instr_enc = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b100001};
            OP_ADDIU: instr_enc = {6'b001001, bus.in_rs, bus.in_rt, bus.in_imm};
            OP_SW:    instr_enc = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
            OP_LW:    instr_enc = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
            OP_JAL:   instr_enc = {6'b000011, bus.in_target};
            default:  op_valid  = 1'b0;
        endcase
    end

    // in_ready depends only on occupancy, so a pop never opens a slot in the same cycle.
    always_comb begin
        full   = (occ_q == OCC_FULL);
        empty  = (occ_q == '0);
        accept = bus.in_valid && !full;
        push   = accept && op_valid;
        pop    = !empty && bus.out_ready;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        addr_d   = addr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            addr_d   = addr_q + ADDR_W'(1);
            count_d  = count_q + 16'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            addr_q   <= ADDR_RESET;
            count_q  <= 16'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{addr: addr_q, instr: instr_enc};
        end
    end

`ifdef INST_ENCODER_ERR_EN
    logic       err_q, err_d;
    logic [2:0] err_op_q, err_op_d;

    always_comb begin
        err_d    = err_q;
        err_op_d = err_op_q;
        if (accept && !op_valid && !err_q) begin
            err_d    = 1'b1;
            err_op_d = bus.in_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q    <= 1'b0;
            err_op_q <= 3'd0;
        end else begin
            err_q    <= err_d;
            err_op_q <= err_op_d;
        end
    end

    assign bus.err    = err_q;
    assign bus.err_op = err_op_q;
`else
    assign bus.err    = 1'b0;
    assign bus.err_op = 3'd0;
`endif

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_instr = empty ? 32'd0 : mem_q[rd_ptr_q].instr;
    assign bus.out_addr  = empty ? '0 : mem_q[rd_ptr_q].addr;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized + directed bench for inst_encoder against a queue-based reference model.
// Expectations for err/err_op follow INST_ENCODER_ERR_EN as the bundle is compiled.
module tb_inst_encoder;
    localparam int ADDR_W    = 10;
    localparam int BASE_ADDR = 0;
    localparam int DEPTH     = 4;
`ifdef INST_ENCODER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        int unsigned addr;
        int unsigned instr;
    } ent_t;

    logic clk;
    logic rst;
    inst_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;

    // Reference model: the FIFO as a queue of expected {addr, word} pairs plus status counters.
    ent_t        modelQ[$];
    int unsigned modelAddr;
    int unsigned modelCount;
    int unsigned modelErr;
    int unsigned modelErrOp;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int unsigned refEncode(input int unsigned op, input int unsigned rs,
                                              input int unsigned rt, input int unsigned rd,
                                              input int unsigned imm, input int unsigned tgt);
        case (op)
            0:       return rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + 33;
            1:       return 9 * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm;
            2:       return 43 * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm;
            3:       return 35 * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm;
            default: return 3 * (1 << 26) + tgt;
        endcase
    endfunction

    task automatic checkState(input string tag);
        checkOutput({tag, ":out_valid"}, {31'd0, bus.out_valid}, (modelQ.size() != 0) ? 32'd1 : 32'd0);
        checkOutput({tag, ":in_ready"}, {31'd0, bus.in_ready}, (modelQ.size() < DEPTH) ? 32'd1 : 32'd0);
        checkOutput({tag, ":count"}, {16'd0, bus.count}, modelCount);
        checkOutput({tag, ":err"}, {31'd0, bus.err}, modelErr);
        checkOutput({tag, ":err_op"}, {29'd0, bus.err_op}, modelErrOp);
        if (modelQ.size() != 0) begin
            checkOutput({tag, ":out_instr"}, bus.out_instr, modelQ[0].instr);
            checkOutput({tag, ":out_addr"}, {22'd0, bus.out_addr}, modelQ[0].addr);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelQ.delete();
        modelAddr  = BASE_ADDR;
        modelCount = 0;
        modelErr   = 0;
        modelErrOp = 0;
        checkState("reset");
        checkOutput("reset:out_instr_zero", bus.out_instr, 32'd0);
        checkOutput("reset:out_addr_zero", {22'd0, bus.out_addr}, 32'd0);
    endtask

    // Drives one cycle of inputs, advances the model across the coming edge, then waits past it.
    task automatic applyStimulus(input bit v, input int unsigned op, input int unsigned rs,
                                 input int unsigned rt, input int unsigned rd, input int unsigned imm,
                                 input int unsigned tgt, input bit ordy, output bit acc);
        bit doPop;
        bus.in_valid  = v;
        bus.in_op     = op[2:0];
        bus.in_rs     = rs[4:0];
        bus.in_rt     = rt[4:0];
        bus.in_rd     = rd[4:0];
        bus.in_imm    = imm[15:0];
        bus.in_target = tgt[25:0];
        bus.out_ready = ordy;
        acc   = v && (modelQ.size() < DEPTH);
        doPop = (modelQ.size() != 0) && ordy;
        if (doPop) void'(modelQ.pop_front());
        if (acc) begin
            if (op <= 4) begin
                modelQ.push_back('{addr: modelAddr, instr: refEncode(op, rs, rt, rd, imm, tgt)});
                modelAddr  = (modelAddr + 1) % (1 << ADDR_W);
                modelCount = (modelCount + 1) % 65536;
            end else if (ERR_EN && modelErr == 0) begin
                modelErr   = 1;
                modelErrOp = op;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;
        bit pendV;
        int unsigned pOp, pRs, pRt, pRd, pImm, pTgt;
        int unsigned expWord[4];
        expWord[0] = 32'h27BDFFF8;
        expWord[1] = 32'hAFBF0004;
        expWord[2] = 32'h8FBF0004;
        expWord[3] = 32'h0C100000;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_rs = 5'd0; bus.in_rt = 5'd0;
        bus.in_rd = 5'd0; bus.in_imm = 16'd0; bus.in_target = 26'd0; bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        doReset();

        // Single addu: visible the cycle after the accept edge.
        applyStimulus(1, 0, 1, 2, 3, 0, 0, 0, acc);
        checkState("addu");
        checkOutput("addu:word", bus.out_instr, 32'h00221821);
        checkOutput("addu:addr", {22'd0, bus.out_addr}, 32'd0);
        checkOutput("addu:count", {16'd0, bus.count}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, acc);
        checkState("addu_drain");

        // Back-to-back stream at full throughput.
        doReset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: applyStimulus(1, 1, 29, 29, 0, 16'hFFF8, 0, 1, acc);
                1: applyStimulus(1, 2, 29, 31, 0, 4, 0, 1, acc);
                2: applyStimulus(1, 3, 29, 31, 0, 4, 0, 1, acc);
                default: applyStimulus(1, 4, 0, 0, 0, 0, 26'h0100000, 1, acc);
            endcase
            checkState("stream");
            checkOutput("stream:word", bus.out_instr, expWord[i]);
            checkOutput("stream:addr", {22'd0, bus.out_addr}, i);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, acc);
        checkState("stream_drain");

        // Backpressure: fill, hold the 5th, pop from full without same-cycle bypass.
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, i, i + 1, i + 2, 0, 0, 0, acc);
            checkState("fill");
        end
        checkOutput("full:in_ready", {31'd0, bus.in_ready}, 32'd0);
        applyStimulus(1, 1, 7, 8, 0, 16'h1234, 0, 0, acc);
        checkState("full_hold");
        checkOutput("full_hold:count", {16'd0, bus.count}, 32'd4);
        applyStimulus(1, 1, 7, 8, 0, 16'h1234, 0, 1, acc);
        checkState("full_pop");
        checkOutput("full_pop:accepted", {31'd0, acc}, 32'd0);
        applyStimulus(1, 1, 7, 8, 0, 16'h1234, 0, 1, acc);
        checkState("fifth_accept");
        checkOutput("fifth_accept:count", {16'd0, bus.count}, 32'd5);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, acc);
            checkState("bp_drain");
        end

        // Invalid ops are consumed but never queued.
        doReset();
        applyStimulus(1, 7, 1, 1, 1, 0, 0, 0, acc);
        checkState("inv7");
        applyStimulus(1, 6, 1, 1, 1, 0, 0, 0, acc);
        checkState("inv6");
        applyStimulus(1, 0, 4, 5, 6, 0, 0, 0, acc);
        checkState("after_inv");
        checkOutput("after_inv:addr", {22'd0, bus.out_addr}, 32'd0);
        checkOutput("after_inv:count", {16'd0, bus.count}, 32'd1);
`ifdef INST_ENCODER_ERR_EN
        checkOutput("after_inv:err", {31'd0, bus.err}, 32'd1);
        checkOutput("after_inv:err_op", {29'd0, bus.err_op}, 32'd7);
`else
        checkOutput("after_inv:err", {31'd0, bus.err}, 32'd0);
`endif

        // Mid-stream reset discards queued entries and restarts the address.
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 3, i, i, 0, i, 0, 0, acc);
            checkState("pre_reset");
        end
        doReset();
        applyStimulus(1, 0, 9, 9, 9, 0, 0, 0, acc);
        checkState("post_reset");
        checkOutput("post_reset:addr", {22'd0, bus.out_addr}, BASE_ADDR);

        // Random traffic; the long reset-free tail wraps the word address.
        pendV = 0;
        pOp = 0; pRs = 0; pRt = 0; pRd = 0; pImm = 0; pTgt = 0;
        for (int c = 0; c < 4000; c++) begin
            bit ordy;
            if (c < 1000 && $urandom_range(0, 299) == 0) begin
                doReset();
                pendV = 0;
                continue;
            end
            if (!pendV) begin
                pendV = ($urandom_range(0, 4) != 0);
                pOp   = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
                pRs   = $urandom_range(0, 31);
                pRt   = $urandom_range(0, 31);
                pRd   = $urandom_range(0, 31);
                pImm  = $urandom_range(0, 65535);
                pTgt  = $urandom & 32'h03FF_FFFF;
            end
            ordy = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            applyStimulus(pendV, pOp, pRs, pRt, pRd, pImm, pTgt, ordy, acc);
            checkState("rand");
            pendV = pendV && !acc;
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/inst_encoder.md
# inst_encoder

Streaming MIPS instruction encoder: it accepts symbolic instructions (operation code plus register, immediate and target fields) over a valid/ready handshake. Each one is packed into a 32-bit MIPS word for the same subset the core's decoder implements: addu, addiu, sw, lw, jal. The word is tagged with a sequential word address and buffered in a small FIFO. It sits between the program loader / self-test generator and the instruction-memory write port, producing exactly the encodings the decoder consumes.

## Interface
- ADDR_W, 10, width of word address and out_addr; wraps at 2^ADDR_W.
- BASE_ADDR, 0, first word address after reset (must fit in ADDR_W bits).
- DEPTH, 4, FIFO entries; power of two, ≥2.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  block can accept this cycle.
- in_op  in  3  0 addu, 1 addiu, 2 sw, 3 lw, 4 jal, 5–7 invalid.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  16  immediate/offset.
- in_target  in  26  jal word target.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream consumes head.
- out_instr  out  32  encoded word.
- out_addr  out  ADDR_W  word address of out_instr.
- count  out  16  accepted valid instructions, wraps at 2^16.
- err  out  1  sticky invalid-op flag.
- err_op  out  3  in_op of the first invalid op.

## Operation
- Accept = in_valid && in_ready. in_ready = !full; it is registered-state only, with no combinational path from out_ready.
- Encoding, MSB first:
  - addu: {6'b000000, rs, rt, rd, 5'b0, 6'b100001}
  - addiu: {6'b001001, rs, rt, imm}
  - sw: {6'b101011, rs, rt, imm}
  - lw: {6'b100011, rs, rt, imm}
  - jal: {6'b000011, target}
  - Unused fields are ignored.
- Valid accepted op:
  - Pushes {addr, instr}.
  - addr increments by 1 modulo 2^ADDR_W.
  - count increments by 1.
- Invalid accepted op (5–7):
  - Consumed with in_ready handshake and not pushed.
  - addr and count unchanged.
  - Error capture per Configuration.
- Pop = out_valid && out_ready, which advances the head.
- out_valid = !empty; out_instr and out_addr are the head entry and hold stable while out_valid && !out_ready.
- Full (DEPTH entries):
  - in_ready = 0, even if a pop occurs the same cycle (no full bypass).
  - Upstream holds its fields.
- Simultaneous push and pop when not full or empty: occupancy is unchanged and order is preserved.
- Reset (also mid-stream):
  - FIFO emptied; in-flight entries are discarded.
  - addr = BASE_ADDR.
  - Outputs: in_ready 1, out_valid 0, out_instr 0, out_addr 0, count 0, err 0, err_op 0.

## Timing
- Latency: accept at edge N → out_valid at cycle N+1 (empty FIFO), with the entry presented the cycle after its push edge.
- Throughput: 1 instruction/cycle when out_ready is held high.
- in_ready falls in the cycle after the push that fills the FIFO; it rises the cycle after the first pop from full.
- err rises the cycle after the invalid accept.

## Configuration
- INST_ENCODER_ERR_EN defined:
  - The first invalid accepted op sets err=1 and captures err_op.
  - Later invalid ops do not overwrite err_op.
  - err is cleared only by rst.
- Undefined: invalid ops are silently dropped; err and err_op are tied 0.

## Test plan
- addu rs=1 rt=2 rd=3 with BASE_ADDR=0 → out_instr 0x00221821, out_addr 0x000, out_valid at N+1, count 1.
- Back-to-back addiu rs=29 rt=29 imm=0xFFF8, sw rs=29 rt=31 imm=4, lw rs=29 rt=31 imm=4, jal target=0x0100000, with out_ready=1 → 0x27BDFFF8, 0xAFBF0004, 0x8FBF0004, 0x0C100000 at addrs 0–3 on consecutive cycles.
- Backpressure, out_ready=0, DEPTH=4, 5 valid inputs → 4 accepted, in_ready 0, 5th held. Then out_ready=1 → all 5 emerge in order; no loss or duplicates.
- in_op=7 then in_op=6 then addu (with INST_ENCODER_ERR_EN) → err=1, err_op=7, next addu tagged addr 0, count 1. Without the macro, err stays 0.
- BASE_ADDR=0x3FF, ADDR_W=10, two valid ops → out_addr 0x3FF then 0x000.
- 3 entries queued, rst pulsed 1 cycle → next cycle out_valid 0, in_ready 1, count 0. The next accept is tagged BASE_ADDR.
